shared_ram_arbiter: RTL and testbench

Shared pattern-RAM controller sitting directly upstream of the function generator. It owns a 32-bit-wide word memory and exposes two Wishbone-classic slave ports: the Caravel bus port, through which firmware loads waveform words, and the RAMBus port, which the generator's fetch FSM reads (8-bit word address). A round-robin arbiter serialises accesses into a single-port memory. It returns a registered ack and data one cycle after grant.

---
 rtl/shared_ram_arbiter_pkg.sv | 37 +++
 rtl/shared_ram_arbiter_ram_bank.sv | 32 +++
 rtl/shared_ram_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_shared_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_ram_arbiter_pkg.sv
// Shared pattern-RAM arbiter: port indices, size defaults, stats field layout
// and the memory request bundle shared by the top level and ram_bank.
package shared_ram_pkg;

  localparam logic PORT_CARAVEL = 1'b0;
  localparam logic PORT_RAMBUS  = 1'b1;

  localparam int          DEFAULT_DEPTH        = 256;
  localparam logic [31:0] DEFAULT_STATS_OFFSET = 32'h0000_0400;

  localparam int STATS_WAIT_LSB = 0;
  localparam int STATS_WAIT_MSB = 15;
  localparam int STATS_RB_LSB   = 16;
  localparam int STATS_RB_MSB   = 31;

  typedef enum logic {
    ARB_LAST_CARAVEL = PORT_CARAVEL,
    ARB_LAST_RAMBUS  = PORT_RAMBUS
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  sel;
    logic [7:0]  idx;
    logic [31:0] wdata;
  } mem_req_t;

  function automatic logic [31:0] stats_pack(input logic [15:0] wait_cnt,
                                             input logic [15:0] rb_cnt);
    logic [31:0] w;
    w = '0;
    w[STATS_WAIT_MSB:STATS_WAIT_LSB] = wait_cnt;
    w[STATS_RB_MSB:STATS_RB_LSB]     = rb_cnt;
    return w;
  endfunction

endpackage

// File: rtl/shared_ram_arbiter_ram_bank.sv
// Single-port DEPTH x 32 pattern memory with byte-lane writes and a registered
// read port. Contents are deliberately not reset.
module ram_bank
  import shared_ram_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    sel,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (sel[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/shared_ram_arbiter.sv
// Two-port Wishbone front end (Caravel, RAMBus) onto one ram_bank, round-robin
// arbitrated, ack one cycle after grant. Define RAM_STATS_EN for the stats register.
//
// state            | meaning
// ARB_LAST_CARAVEL | last grant went to Caravel; RAMBus wins a tie
// ARB_LAST_RAMBUS  | last grant went to RAMBus; Caravel wins a tie (reset)
module shared_ram_arbiter
  import shared_ram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_1000,
  parameter int          DEPTH        = DEFAULT_DEPTH,
  parameter logic [31:0] STATS_OFFSET = DEFAULT_STATS_OFFSET
) (
  input  logic        caravel_wb_clk_i,
  input  logic        caravel_wb_rst_i,
  input  logic        caravel_wb_stb_i,
  input  logic        caravel_wb_cyc_i,
  input  logic        caravel_wb_we_i,
  input  logic [3:0]  caravel_wb_sel_i,
  input  logic [31:0] caravel_wb_adr_i,
  input  logic [31:0] caravel_wb_dat_i,
  output logic        caravel_wb_ack_o,
  output logic [31:0] caravel_wb_dat_o,
  input  logic        rambus_wb_stb_i,
  input  logic        rambus_wb_cyc_i,
  input  logic        rambus_wb_we_i,
  input  logic [3:0]  rambus_wb_sel_i,
  input  logic [7:0]  rambus_wb_adr_i,
  input  logic [31:0] rambus_wb_dat_i,
  output logic        rambus_wb_ack_o,
  output logic [31:0] rambus_wb_dat_o
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [31:0] RAM_BYTES  = 32'(4 * DEPTH);
  localparam logic [29:0] STATS_WORD = 30'((BASE_ADDRESS + STATS_OFFSET) >> 2);

  logic [31:0]   car_off;
  logic          car_req_any, car_in_win, car_stats_adr;
  logic          car_ram_hit, car_stats_hit;
  logic          rb_req;
  logic          car_elig, rb_elig;
  logic          grant_car, grant_rb;
  logic [AW-1:0] car_idx, rb_idx;

  assign car_req_any   = caravel_wb_stb_i & caravel_wb_cyc_i;
  assign car_off       = caravel_wb_adr_i - BASE_ADDRESS;
  assign car_in_win    = (caravel_wb_adr_i >= BASE_ADDRESS) && (car_off < RAM_BYTES);
  assign car_stats_adr = (caravel_wb_adr_i[31:2] == STATS_WORD);
  // The stats word is reserved in both builds so the RAM map never depends on the option.
  assign car_ram_hit   = car_req_any & car_in_win & ~car_stats_adr;
  assign car_idx       = AW'(car_off >> 2);

  assign rb_req = rambus_wb_stb_i & rambus_wb_cyc_i;
  assign rb_idx = AW'(rambus_wb_adr_i);

`ifdef RAM_STATS_EN
  assign car_stats_hit = car_req_any & car_stats_adr;
`else
  assign car_stats_hit = 1'b0;
`endif

  // A port whose ack is high is still holding stb for the current grant.
  assign car_elig = (car_ram_hit | car_stats_hit) & ~caravel_wb_ack_o;
  assign rb_elig  = rb_req & ~rambus_wb_ack_o;

  arb_state_e state_q, state_d;

  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) state_q <= ARB_LAST_RAMBUS;
    else                  state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (grant_car)     state_d = ARB_LAST_CARAVEL;
    else if (grant_rb) state_d = ARB_LAST_RAMBUS;
  end

  always_comb begin
    grant_car = 1'b0;
    grant_rb  = 1'b0;
    case (state_q)
      ARB_LAST_RAMBUS: begin
        grant_car = car_elig;
        grant_rb  = rb_elig & ~car_elig;
      end
      default: begin
        grant_rb  = rb_elig;
        grant_car = car_elig & ~rb_elig;
      end
    endcase
  end

  mem_req_t    mreq;
  logic        mem_en;
  logic [31:0] ram_rdata;

  always_comb begin
    mreq = '0;
    if (grant_car) begin
      mreq.we    = caravel_wb_we_i;
      mreq.sel   = caravel_wb_sel_i;
      mreq.idx   = 8'(car_idx);
      mreq.wdata = caravel_wb_dat_i;
    end else begin
      mreq.we    = rambus_wb_we_i;
      mreq.sel   = rambus_wb_sel_i;
      mreq.idx   = 8'(rb_idx);
      mreq.wdata = rambus_wb_dat_i;
    end
  end

  assign mem_en = (grant_car & car_ram_hit) | grant_rb;

  ram_bank #(.DEPTH(DEPTH)) u_ram_bank (
    .clk   (caravel_wb_clk_i),
    .en    (mem_en),
    .we    (mreq.we),
    .sel   (mreq.sel),
    .addr  (AW'(mreq.idx)),
    .wdata (mreq.wdata),
    .rdata (ram_rdata)
  );

  logic [31:0] car_rd_word;
  logic        car_rd_q, rb_rd_q;
  logic [31:0] car_hold_q, rb_hold_q;

`ifdef RAM_STATS_EN
  logic [15:0] wait_cnt_q, rb_cnt_q;
  logic        stats_rd_q;
  logic [31:0] stats_snap_q;
  logic        lost, stats_rd_grant, stats_wr_grant;

  // At most one port can lose per cycle, so this counts contention cycles.
  assign lost           = (car_elig & ~grant_car) | (rb_elig & ~grant_rb);
  assign stats_rd_grant = grant_car & car_stats_hit & ~caravel_wb_we_i;
  assign stats_wr_grant = grant_car & car_stats_hit & caravel_wb_we_i;

  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) begin
      wait_cnt_q   <= '0;
      rb_cnt_q     <= '0;
      stats_rd_q   <= 1'b0;
      stats_snap_q <= '0;
    end else begin
      stats_rd_q <= stats_rd_grant;
      if (stats_rd_grant) stats_snap_q <= stats_pack(wait_cnt_q, rb_cnt_q);
      if (stats_wr_grant) begin
        wait_cnt_q <= '0;
        rb_cnt_q   <= '0;
      end else begin
        if (lost && wait_cnt_q != 16'hFFFF) wait_cnt_q <= wait_cnt_q + 16'd1;
        if (grant_rb) rb_cnt_q <= rb_cnt_q + 16'd1;
      end
    end
  end

  assign car_rd_word = stats_rd_q ? stats_snap_q : ram_rdata;
`else
  assign car_rd_word = ram_rdata;
`endif

  always_ff @(posedge caravel_wb_clk_i or posedge caravel_wb_rst_i) begin
    if (caravel_wb_rst_i) begin
      caravel_wb_ack_o <= 1'b0;
      rambus_wb_ack_o  <= 1'b0;
      car_rd_q         <= 1'b0;
      rb_rd_q          <= 1'b0;
      car_hold_q       <= '0;
      rb_hold_q        <= '0;
    end else begin
      caravel_wb_ack_o <= grant_car;
      rambus_wb_ack_o  <= grant_rb;
      car_rd_q         <= grant_car & ~caravel_wb_we_i;
      rb_rd_q          <= grant_rb & ~rambus_wb_we_i;
      if (car_rd_q) car_hold_q <= car_rd_word;
      if (rb_rd_q)  rb_hold_q  <= ram_rdata;
    end
  end

  // The bank's output register is shared; each port keeps its last read word otherwise.
  assign caravel_wb_dat_o = car_rd_q ? car_rd_word : car_hold_q;
  assign rambus_wb_dat_o  = rb_rd_q ? ram_rdata : rb_hold_q;

endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Scoreboard bench for shared_ram_arbiter (DEPTH=64); stats checks compile in
// when RAM_STATS_EN is defined.
module tb_shared_ram_arbiter;

  localparam logic [31:0] BASE      = 32'h3000_1000;
  localparam int          DEPTH     = 64;
  localparam logic [31:0] STATS_OFF = 32'h0000_0400;

  logic        clk, rst;
  logic        car_stb, car_cyc, car_we;
  logic [3:0]  car_sel;
  logic [31:0] car_adr, car_dat_w;
  logic        car_ack;
  logic [31:0] car_dat_r;
  logic        rb_stb, rb_cyc, rb_we;
  logic [3:0]  rb_sel;
  logic [7:0]  rb_adr;
  logic [31:0] rb_dat_w;
  logic        rb_ack;
  logic [31:0] rb_dat_r;

  shared_ram_arbiter #(.BASE_ADDRESS(BASE), .DEPTH(DEPTH), .STATS_OFFSET(STATS_OFF)) dut (
    .caravel_wb_clk_i (clk),
    .caravel_wb_rst_i (rst),
    .caravel_wb_stb_i (car_stb),
    .caravel_wb_cyc_i (car_cyc),
    .caravel_wb_we_i  (car_we),
    .caravel_wb_sel_i (car_sel),
    .caravel_wb_adr_i (car_adr),
    .caravel_wb_dat_i (car_dat_w),
    .caravel_wb_ack_o (car_ack),
    .caravel_wb_dat_o (car_dat_r),
    .rambus_wb_stb_i  (rb_stb),
    .rambus_wb_cyc_i  (rb_cyc),
    .rambus_wb_we_i   (rb_we),
    .rambus_wb_sel_i  (rb_sel),
    .rambus_wb_adr_i  (rb_adr),
    .rambus_wb_dat_i  (rb_dat_w),
    .rambus_wb_ack_o  (rb_ack),
    .rambus_wb_dat_o  (rb_dat_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic        rd;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t        car_q[$];
  exp_t        rb_q[$];
  logic [31:0] model [DEPTH];

  always @(negedge clk) begin
    exp_t e;
    if (car_ack) begin
      chk("car_ack_expected", 32'(car_q.size() != 0), 32'd1);
      if (car_q.size() != 0) begin
        e = car_q.pop_front();
        if (e.rd) chk(e.tag, car_dat_r, e.data);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rb_ack) begin
      chk("rb_ack_expected", 32'(rb_q.size() != 0), 32'd1);
      if (rb_q.size() != 0) begin
        e = rb_q.pop_front();
        if (e.rd) chk(e.tag, rb_dat_r, e.data);
      end
    end
  end

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [3:0] sel,
                                        input logic [31:0] d);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // exp_lat < 0 means only the worst-case bound of 2 cycles is checked.
  task automatic access(input int port, input logic we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat,
                        input logic [31:0] exp_rd, input int exp_lat, input string tag);
    exp_t e;
    int   lat;
    logic ack;
    @(negedge clk);
    e.rd = ~we; e.data = exp_rd; e.tag = tag;
    if (port == 0) begin
      car_q.push_back(e);
      car_stb = 1'b1; car_cyc = 1'b1; car_we = we; car_sel = sel; car_adr = adr; car_dat_w = dat;
    end else begin
      rb_q.push_back(e);
      rb_stb = 1'b1; rb_cyc = 1'b1; rb_we = we; rb_sel = sel; rb_adr = adr[7:0]; rb_dat_w = dat;
    end
    lat = 0;
    ack = 1'b0;
    while (!ack && lat < 8) begin
      @(negedge clk);
      lat++;
      ack = (port == 0) ? car_ack : rb_ack;
    end
    if (port == 0) begin car_stb = 1'b0; car_cyc = 1'b0; end
    else begin rb_stb = 1'b0; rb_cyc = 1'b0; end
    chk({tag, "_acked"}, 32'(ack), 32'd1);
    if (!ack) begin
      if (port == 0) void'(car_q.pop_back());
      else void'(rb_q.pop_back());
    end else if (exp_lat >= 0) begin
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    end else begin
      chk({tag, "_lat_le2"}, 32'(lat <= 2), 32'd1);
    end
  endtask

  task automatic car_wr(input int w, input logic [3:0] sel, input logic [31:0] d, input int lat);
    model[w] = merge(model[w], sel, d);
    access(0, 1'b1, BASE + 32'(4 * w), sel, d, 32'd0, lat, "car_wr");
  endtask

  task automatic car_rd(input int w, input int lat);
    access(0, 1'b0, BASE + 32'(4 * w), 4'hF, 32'd0, model[w], lat, "car_rd");
  endtask

  task automatic rb_wr(input int w, input logic [3:0] sel, input logic [31:0] d, input int lat);
    model[w] = merge(model[w], sel, d);
    access(1, 1'b1, 32'(w), sel, d, 32'd0, lat, "rb_wr");
  endtask

  task automatic rb_rd(input int w, input int lat);
    access(1, 1'b0, 32'(w), 4'hF, 32'd0, model[w], lat, "rb_rd");
  endtask

  task automatic car_noack(input logic we, input logic [31:0] adr, input logic [31:0] d,
                           input string tag);
    int seen;
    seen = 0;
    @(negedge clk);
    car_stb = 1'b1; car_cyc = 1'b1; car_we = we; car_sel = 4'hF; car_adr = adr; car_dat_w = d;
    repeat (4) begin
      @(negedge clk);
      if (car_ack) seen++;
    end
    car_stb = 1'b0; car_cyc = 1'b0;
    chk(tag, 32'(seen), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    car_stb = 0; car_cyc = 0; car_we = 0; car_sel = 0; car_adr = 0; car_dat_w = 0;
    rb_stb = 0; rb_cyc = 0; rb_we = 0; rb_sel = 0; rb_adr = 0; rb_dat_w = 0;
    repeat (3) @(negedge clk);
    chk("rst_car_ack", 32'(car_ack), 32'd0);
    chk("rst_rb_ack", 32'(rb_ack), 32'd0);
    chk("rst_car_dat", car_dat_r, 32'd0);
    chk("rst_rb_dat", rb_dat_r, 32'd0);
    rst = 1'b0;

    car_wr(2, 4'hF, 32'hDEAD_BEEF, 1);
    access(1, 1'b0, 32'd2, 4'hF, 32'd0, 32'hDEAD_BEEF, 1, "rb_rd_deadbeef");

    // First tie after rambus-last: Caravel wins; a Caravel grant then hands the next tie to RAMBus.
    rb_wr(5, 4'hF, 32'hA5A5_0005, 1);
    rb_wr(6, 4'hF, 32'h5A5A_0006, 1);
    fork
      car_rd(5, 1);
      rb_rd(6, 2);
    join
    car_wr(7, 4'hF, 32'h0707_0707, 1);
    fork
      car_rd(6, 2);
      rb_rd(5, 1);
    join

    rb_wr(0, 4'hF, 32'h1122_3344, 1);
    car_wr(0, 4'b0101, 32'hAABB_CCDD, 1);
    access(0, 1'b0, BASE, 4'hF, 32'd0, 32'h11BB_33DD, 1, "car_rd_bytes");
    access(1, 1'b0, 32'd0, 4'hF, 32'd0, 32'h11BB_33DD, 1, "rb_rd_bytes");
    car_rd(2, 1);
    chk("rb_dat_hold", rb_dat_r, 32'h11BB_33DD);

    model[63] = 32'h6363_6363;
    access(1, 1'b1, 32'h0000_00FF, 4'hF, 32'h6363_6363, 32'd0, 1, "rb_wr_ff");
    access(0, 1'b0, BASE + 32'(4 * 63), 4'hF, 32'd0, 32'h6363_6363, 1, "car_rd_w63");
    car_noack(1'b1, BASE + 32'(4 * DEPTH), 32'hBAD0_0000, "oow_hi_noack");
    car_noack(1'b1, BASE - 32'd4, 32'hBAD0_0001, "oow_lo_noack");
`ifndef RAM_STATS_EN
    car_noack(1'b0, BASE + STATS_OFF, 32'd0, "stats_absent_noack");
`endif
    access(0, 1'b0, BASE, 4'hF, 32'd0, 32'h11BB_33DD, 1, "w0_unchanged");
    access(0, 1'b0, BASE + 32'(4 * 63), 4'hF, 32'd0, 32'h6363_6363, 1, "w63_unchanged");

    for (int w = 16; w < 32; w++) car_wr(w, 4'hF, $urandom, 1);
    for (int w = 32; w < 48; w++) rb_wr(w, 4'hF, $urandom, 1);
    for (int i = 0; i < 12; i++) begin
      int          cw, rw;
      logic        cop, rop;
      logic [3:0]  cs, rs;
      logic [31:0] cd, rd;
      cw = 16 + $urandom_range(0, 15); rw = 32 + $urandom_range(0, 15);
      cop = 1'($urandom_range(0, 1)); rop = 1'($urandom_range(0, 1));
      cs = 4'($urandom); rs = 4'($urandom);
      cd = $urandom; rd = $urandom;
      fork
        if (cop) car_wr(cw, cs, cd, -1); else car_rd(cw, -1);
        if (rop) rb_wr(rw, rs, rd, -1); else rb_rd(rw, -1);
      join
    end

    // Reset lands in the ack cycle of a read: the ack must never be seen.
    car_rd(2, 1);
    rb_rd(0, 1);
    @(negedge clk);
    car_stb = 1'b1; car_cyc = 1'b1; car_we = 1'b0; car_sel = 4'hF; car_adr = BASE + 32'd8;
    rb_stb = 1'b1; rb_cyc = 1'b1; rb_we = 1'b0; rb_sel = 4'hF; rb_adr = 8'd5;
    @(posedge clk);
    rst = 1'b1;
    car_stb = 1'b0; car_cyc = 1'b0; rb_stb = 1'b0; rb_cyc = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_car_ack", 32'(car_ack), 32'd0);
      chk("rstmid_rb_ack", 32'(rb_ack), 32'd0);
      chk("rstmid_car_dat", car_dat_r, 32'd0);
      chk("rstmid_rb_dat", rb_dat_r, 32'd0);
    end
    rst = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("postrst_car_ack", 32'(car_ack), 32'd0);
      chk("postrst_rb_ack", 32'(rb_ack), 32'd0);
    end
    car_rd(5, 1);

`ifdef RAM_STATS_EN
    access(0, 1'b0, BASE + STATS_OFF, 4'hF, 32'd0, 32'd0, 1, "stats_after_rst");
    for (int k = 0; k < 10; k++) begin
      fork
        car_rd(16 + k, -1);
        rb_rd(32 + k, -1);
      join
    end
    access(0, 1'b0, BASE + STATS_OFF, 4'hF, 32'd0, {16'd10, 16'd10}, 1, "stats_contended");
    access(0, 1'b1, BASE + STATS_OFF, 4'hF, 32'hFFFF_FFFF, 32'd0, 1, "stats_clear_wr");
    access(0, 1'b0, BASE + STATS_OFF, 4'hF, 32'd0, 32'd0, 1, "stats_cleared");
`endif

    repeat (3) @(negedge clk);
    chk("car_q_drained", 32'(car_q.size()), 32'd0);
    chk("rb_q_drained", 32'(rb_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
